// File: rtl/alu_exec_unit_if.sv
// Handshake and operand/result bus for alu_exec_unit.
// The master side offers operations and drains results; the slave side is the unit.
interface alu_exec_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, alu_control, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_control, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: executes one ALU_control-coded operation per handshake.
// Logic/arithmetic ops complete in one cycle. Shifts step one bit per cycle
// through the SHIFT state, unless ALU_EXEC_FAST_SHIFT_EN is defined, in which
// case a barrel shifter is used and every op finishes in one cycle.
// The result, zero and illegal flags are registered and held in DONE until drained.
module alu_exec_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input logic            clk,
  input logic            rst_n,
  alu_exec_unit_if.slave bus
);
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic            accept_s;
  logic [SHW-1:0]  shamt_s;
  logic [XLEN-1:0] comb_result_s;
  logic            comb_illegal_s;
  logic            slt_s;
  logic [XLEN-1:0] result_r;
  logic            zero_r;
  logic            illegal_r;

`ifndef ALU_EXEC_FAST_SHIFT_EN
  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};
  logic            is_shift_s;
  logic [XLEN-1:0] work_r;
  logic [SHW-1:0]  cnt_r;
  logic [3:0]      op_r;
  logic [XLEN-1:0] shift_step_s;
`endif

  assign accept_s = bus.in_valid & (state_r == IDLE);
  assign shamt_s  = bus.operand_b[SHW-1:0];
  assign slt_s    = ($signed(bus.operand_a) < $signed(bus.operand_b));

`ifndef ALU_EXEC_FAST_SHIFT_EN
  assign is_shift_s = (bus.alu_control == OP_SLL) | (bus.alu_control == OP_SRL) |
                      (bus.alu_control == OP_SRA);
`endif

  // Single-cycle result for the offered code; shifts give the barrel result or the zero-amount passthrough.
  always_comb begin
    comb_result_s  = {XLEN{1'b0}};
    comb_illegal_s = 1'b0;
    case (bus.alu_control)
      OP_AND: comb_result_s = bus.operand_a & bus.operand_b;
      OP_OR:  comb_result_s = bus.operand_a | bus.operand_b;
      OP_ADD: comb_result_s = bus.operand_a + bus.operand_b;
      OP_XOR: comb_result_s = bus.operand_a ^ bus.operand_b;
      OP_SUB: comb_result_s = bus.operand_a - bus.operand_b;
      OP_SLT: comb_result_s = {{(XLEN-1){1'b0}}, slt_s};
`ifdef ALU_EXEC_FAST_SHIFT_EN
      OP_SLL: comb_result_s = bus.operand_a << shamt_s;
      OP_SRL: comb_result_s = bus.operand_a >> shamt_s;
      OP_SRA: comb_result_s = $unsigned($signed(bus.operand_a) >>> shamt_s);
`else
      OP_SLL: comb_result_s = bus.operand_a;
      OP_SRL: comb_result_s = bus.operand_a;
      OP_SRA: comb_result_s = bus.operand_a;
`endif
      default: begin
        comb_result_s  = {XLEN{1'b0}};
        comb_illegal_s = 1'b1;
      end
    endcase
  end

`ifndef ALU_EXEC_FAST_SHIFT_EN
  // One-bit step of the working register for the latched shift kind; SRA refills with the MSB.
  always_comb begin
    shift_step_s = work_r;
    case (op_r)
      OP_SLL:  shift_step_s = {work_r[XLEN-2:0], 1'b0};
      OP_SRL:  shift_step_s = {1'b0, work_r[XLEN-1:1]};
      OP_SRA:  shift_step_s = {work_r[XLEN-1], work_r[XLEN-1:1]};
      default: shift_step_s = work_r;
    endcase
  end
`endif

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: accept in IDLE, count down in SHIFT, wait for drain in DONE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
`ifdef ALU_EXEC_FAST_SHIFT_EN
          state_nxt_s = DONE;
`else
          if (is_shift_s && (shamt_s != {SHW{1'b0}})) begin
            state_nxt_s = SHIFT;
          end else begin
            state_nxt_s = DONE;
          end
`endif
        end else begin
          state_nxt_s = IDLE;
        end
      end
`ifndef ALU_EXEC_FAST_SHIFT_EN
      SHIFT: begin
        if (cnt_r == CNT_ONE) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
`endif
      DONE: begin
        if (bus.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state register.
  always_comb begin
    bus.in_ready  = (state_r == IDLE);
    bus.out_valid = (state_r == DONE);
  end

  // Datapath: latch operands on accept, step the shifter, capture the final result and flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_r  <= {XLEN{1'b0}};
      zero_r    <= 1'b0;
      illegal_r <= 1'b0;
`ifndef ALU_EXEC_FAST_SHIFT_EN
      work_r    <= {XLEN{1'b0}};
      cnt_r     <= {SHW{1'b0}};
      op_r      <= 4'b0000;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            result_r  <= comb_result_s;
            zero_r    <= (comb_result_s == {XLEN{1'b0}});
            illegal_r <= comb_illegal_s;
`ifndef ALU_EXEC_FAST_SHIFT_EN
            work_r    <= bus.operand_a;
            cnt_r     <= shamt_s;
            op_r      <= bus.alu_control;
`endif
          end
        end
`ifndef ALU_EXEC_FAST_SHIFT_EN
        SHIFT: begin
          work_r <= shift_step_s;
          cnt_r  <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            result_r <= shift_step_s;
            zero_r   <= (shift_step_s == {XLEN{1'b0}});
          end
        end
`endif
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

  assign bus.result  = result_r;
  assign bus.zero    = zero_r;
  assign bus.illegal = illegal_r;
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

- Execution-side consumer of the 4-bit `alu_control` code produced by ALU control decode.
- Accepts one operation per valid/ready handshake: the code plus two XLEN-bit operands.
- Logic/arithmetic ops complete in one cycle; shifts run iteratively one bit per cycle.
- Returns a registered result with `zero` and `illegal` flags, held until the downstream accepts it.
- Sits between decode/operand fetch and writeback/branch resolution in the multi-cycle datapath.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; must be a power of two ≥ 8.
- `SHW`, $clog2(XLEN): shift-amount width; shift amount is `operand_b[SHW-1:0]`.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `alu_control`  in  4  operation code (map below).
- `operand_a`  in  XLEN  first operand / shift source.
- `operand_b`  in  XLEN  second operand / shift amount.
- `out_valid`  out  1  result registered and held.
- `out_ready`  in  1  downstream accepts result.
- `result`  out  XLEN  operation result.
- `zero`  out  1  `result == 0`.
- `illegal`  out  1  code not in map.

## Operation
- Code map:
  - `0000` AND; `0001` OR; `0010` ADD; `0011` XOR.
  - `0110` SUB; `0111` SLT (signed, result 1 or 0).
  - `0100` SLL; `0101` SRL; `1000` SRA.
  - All other codes, including `1111`: illegal.
- ADD/SUB: modulo 2^XLEN; carry and overflow discarded.
- Operands and code are latched on accept; input changes after accept have no effect.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE → DONE on accept of a non-shift or illegal op; result computed and registered on the accept edge.
  - IDLE → SHIFT on accept of SLL/SRL/SRA with shift amount n > 0.
    - Working register loaded with `operand_a`.
    - Counter loaded with n.
  - IDLE → DONE on accept of a shift with n = 0; result = `operand_a`.
  - SHIFT: each cycle shift the working register by one bit and decrement the counter.
    - SRA replicates the MSB.
    - When the counter reaches 1 on the current edge, go to DONE.
  - DONE: `out_valid`=1; `result`, `zero`, `illegal` stable. On `out_valid & out_ready` → IDLE.
- Illegal op: `result`=0, `zero`=1, `illegal`=1.
- `in_ready` = (state == IDLE); no accept in the same cycle a result is drained.

## Timing
- Reset: on a `clk` edge with `rst_n`=0, go to IDLE.
  - `in_ready`=1 from the following cycle.
  - `out_valid`=0, `result`=0, `zero`=0, `illegal`=0.
  - Counter and working register cleared.
- Reset mid-SHIFT or in DONE: operation and result discarded; nothing emitted.
- Accept at edge t:
  - Non-shift or n=0 shift: `out_valid`=1 from t+1.
  - Iterative shift by n: `out_valid`=1 from t+n+1.
- Result hold: `out_valid` stays high and outputs are frozen indefinitely while `out_ready`=0.
- Drain at edge d: `out_valid`=0 and `in_ready`=1 from d+1.
- Best-case throughput: one op per 2 cycles.
- Maximum latency: XLEN cycles (n = XLEN-1).
- `out_ready` high while `out_valid`=0: ignored.
- `in_valid` while not IDLE: ignored; the offer must be held by the source.

## Configuration
- `ALU_EXEC_FAST_SHIFT_EN` defined:
  - Shifts use a single-cycle barrel shifter; SHIFT state not built.
  - Every op goes IDLE → DONE; latency 1.
- Not defined: iterative shifter as above.
  - Results are bit-identical in both builds; only latency differs.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles during a SHIFT → `out_valid`=0, `result`=0, `in_ready`=1 the cycle after release.
- SUB 5−5, `out_ready`=1 → `out_valid` at t+1, `result`=0, `zero`=1, `illegal`=0, then `in_ready` back next cycle.
- SLT a=0xFFFFFFFF, b=1 → `result`=1; SRA a=0x80000000, b=4 → `result`=0xF8000000.
  - SRA latency: 5 cycles iterative, 1 cycle with macro.
- SLL a=1, b=31 → `result`=0x80000000, `out_valid` at t+32; b=0 → `result`=1 at t+1.
- Backpressure: ADD 7+9 with `out_ready`=0 for 10 cycles → `result`=16 stable, `in_ready`=0, second `in_valid` ignored until drain.
- Code `1111` → `illegal`=1, `result`=0, `zero`=1; code `1010` → same.
